cyclic_ready_picker: RTL and testbench



---
 rtl/cyclic_ready_picker_if.sv | 28 ++
 rtl/cyclic_ready_picker.sv | 143 ++++++++++++++
 tb/tb_cyclic_ready_picker.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cyclic_ready_picker_if.sv
// Handshake bundle between the cyclic entry tracker and its client.
// master: allocator / marker / issue consumer / retirer.
// slave : cyclic_ready_picker.
interface cyclic_ready_picker_if #(
    parameter int unsigned LOG_WIDTH = 3
);
    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [LOG_WIDTH-1:0] alloc_idx;
    logic                 mark_valid;
    logic [LOG_WIDTH-1:0] mark_idx;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [LOG_WIDTH-1:0] issue_idx;
    logic                 retire_valid;
    logic [LOG_WIDTH-1:0] head_idx;
    logic [LOG_WIDTH:0]   count;

    modport master (
        output alloc_valid, mark_valid, mark_idx, issue_ready, retire_valid,
        input  alloc_ready, alloc_idx, issue_valid, issue_idx, head_idx, count
    );

    modport slave (
        input  alloc_valid, mark_valid, mark_idx, issue_ready, retire_valid,
        output alloc_ready, alloc_idx, issue_valid, issue_idx, head_idx, count
    );
endinterface

// File: rtl/cyclic_ready_picker.sv
// Cyclic-buffer entry tracker for prefetch queues: allocates at tail,
// retires at head, and issues the oldest pending occupied entry found by
// a cyclic search from head.
// Optional macro CYCLIC_PICKER_ERR_CHECK_EN adds a sticky error output
// flagging retire-while-empty, mark-to-unoccupied and alloc-while-full.
module cyclic_ready_picker #(
    parameter int unsigned LOG_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     resetN,
    cyclic_ready_picker_if.slave     bus
`ifdef CYCLIC_PICKER_ERR_CHECK_EN
    ,
    output logic                     err_sticky
`endif
);
    localparam int unsigned WIDTH = 1 << LOG_WIDTH;
    localparam int unsigned CNT_W = LOG_WIDTH + 1;

    logic [LOG_WIDTH-1:0] r_head;
    logic [LOG_WIDTH-1:0] r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [WIDTH-1:0]     r_pending;

    logic [WIDTH-1:0]     w_occupied;
    logic [WIDTH-1:0]     w_cand;
    logic [WIDTH-1:0]     w_rot;
    logic [LOG_WIDTH-1:0] w_first;
    logic                 w_any;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_alloc_fire;
    logic                 w_issue_fire;
    logic                 w_retire_fire;
    logic                 w_mark_ok;
    logic [LOG_WIDTH-1:0] w_issue_idx;
    logic [WIDTH-1:0]     w_pending_nxt;

    assign w_full  = (r_count == CNT_W'(WIDTH));
    assign w_empty = (r_count == '0);

    // Occupied entries are those whose distance from head is below count.
    always_comb begin : occ_blk
        logic [LOG_WIDTH-1:0] off;
        off        = '0;
        w_occupied = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            off           = LOG_WIDTH'(i) - r_head;
            w_occupied[i] = ({1'b0, off} < r_count);
        end
    end

    assign w_cand = r_pending & w_occupied;

    // Rotate candidates so that head sits at bit 0 (bit k = age rank k).
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            w_rot[k] = w_cand[LOG_WIDTH'(k) + r_head];
        end
    end

    // Lowest set bit of the rotated vector is the oldest candidate.
    always_comb begin
        w_first = '0;
        w_any   = 1'b0;
        for (int k = int'(WIDTH) - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_first = LOG_WIDTH'(k);
                w_any   = 1'b1;
            end
        end
    end

    assign w_issue_idx   = r_head + w_first;
    assign w_alloc_fire  = bus.alloc_valid && !w_full;
    assign w_issue_fire  = w_any && bus.issue_ready;
    assign w_retire_fire = bus.retire_valid && !w_empty;
    assign w_mark_ok     = bus.mark_valid && w_occupied[bus.mark_idx];

    // Clears first, then an accepted mark sets unless retire frees that entry.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_alloc_fire) begin
            w_pending_nxt[r_tail] = 1'b0;
        end
        if (w_issue_fire) begin
            w_pending_nxt[w_issue_idx] = 1'b0;
        end
        if (w_retire_fire) begin
            w_pending_nxt[r_head] = 1'b0;
        end
        if (w_mark_ok && !(w_retire_fire && (bus.mark_idx == r_head))) begin
            w_pending_nxt[bus.mark_idx] = 1'b1;
        end
    end

    // Pointer, occupancy and pending state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_alloc_fire) begin
                r_tail <= r_tail + LOG_WIDTH'(1);
            end
            if (w_retire_fire) begin
                r_head <= r_head + LOG_WIDTH'(1);
            end
            r_count <= r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_retire_fire);
        end
    end

`ifdef CYCLIC_PICKER_ERR_CHECK_EN
    logic r_err;
    logic w_err_evt;

    assign w_err_evt = (bus.retire_valid && w_empty)
                     || (bus.mark_valid && !w_occupied[bus.mark_idx])
                     || (bus.alloc_valid && w_full);

    // Sticky flag for any illegal request; only reset clears it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign err_sticky = r_err;
`endif

    assign bus.alloc_ready = !w_full;
    assign bus.alloc_idx   = r_tail;
    assign bus.issue_valid = w_any;
    assign bus.issue_idx   = w_issue_idx;
    assign bus.head_idx    = r_head;
    assign bus.count       = r_count;
endmodule

// File: tb/tb_cyclic_ready_picker.sv
// Self-checking bench for cyclic_ready_picker: directed scenarios plus
// randomized traffic against an entry-list reference model.
module tb_cyclic_ready_picker;
    localparam int LW = 3;
    localparam int W  = 1 << LW;

    logic clk;
    logic resetN;
`ifdef CYCLIC_PICKER_ERR_CHECK_EN
    logic err_sticky;
`endif

    cyclic_ready_picker_if #(.LOG_WIDTH(LW)) bus ();

    cyclic_ready_picker #(.LOG_WIDTH(LW)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .bus        (bus)
`ifdef CYCLIC_PICKER_ERR_CHECK_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: head, tail, count as integers plus a pending flag per slot.
    int m_head, m_tail, m_cnt;
    bit m_pend [W];
    bit m_err;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_occ(input int idx);
        return ((idx - m_head + W) % W) < m_cnt;
    endfunction

    // Oldest pending occupied entry: walk entries in age order from head.
    function automatic int m_pick(output bit valid);
        valid = 1'b0;
        for (int k = 0; k < m_cnt; k++) begin
            if (m_pend[(m_head + k) % W]) begin
                valid = 1'b1;
                return (m_head + k) % W;
            end
        end
        return m_head;
    endfunction

    task automatic m_reset();
        m_head = 0; m_tail = 0; m_cnt = 0; m_err = 1'b0;
        for (int i = 0; i < W; i++) m_pend[i] = 1'b0;
    endtask

    task automatic check_state();
        bit iv;
        int ii;
        ii = m_pick(iv);
        chk_eq("alloc_ready", int'(bus.alloc_ready), int'(m_cnt != W));
        chk_eq("alloc_idx",   int'(bus.alloc_idx),   m_tail);
        chk_eq("issue_valid", int'(bus.issue_valid), int'(iv));
        chk_eq("issue_idx",   int'(bus.issue_idx),   ii);
        chk_eq("head_idx",    int'(bus.head_idx),    m_head);
        chk_eq("count",       int'(bus.count),       m_cnt);
`ifdef CYCLIC_PICKER_ERR_CHECK_EN
        chk_eq("err_sticky",  int'(err_sticky),      int'(m_err));
`endif
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic cyc(input bit av, input bit mv, input int mi, input bit ir, input bit rv);
        bit iv, af, rf, isf, mk;
        int ii;
        bit np [W];
        bus.alloc_valid  = av;
        bus.mark_valid   = mv;
        bus.mark_idx     = LW'(mi);
        bus.issue_ready  = ir;
        bus.retire_valid = rv;
        ii  = m_pick(iv);
        af  = av && (m_cnt != W);
        rf  = rv && (m_cnt != 0);
        isf = ir && iv;
        mk  = mv && m_occ(mi);
        if ((rv && m_cnt == 0) || (mv && !m_occ(mi)) || (av && m_cnt == W)) m_err = 1'b1;
        np = m_pend;
        if (af)  np[m_tail] = 1'b0;
        if (isf) np[ii]     = 1'b0;
        if (rf)  np[m_head] = 1'b0;
        if (mk && !(rf && mi == m_head)) np[mi] = 1'b1;
        @(posedge clk);
        m_pend = np;
        m_tail = (m_tail + int'(af)) % W;
        m_head = (m_head + int'(rf)) % W;
        m_cnt  = m_cnt + int'(af) - int'(rf);
        @(negedge clk);
        check_state();
    endtask

    task automatic idle_inputs();
        bus.alloc_valid  = 1'b0;
        bus.mark_valid   = 1'b0;
        bus.mark_idx     = '0;
        bus.issue_ready  = 1'b0;
        bus.retire_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        resetN = 1'b0;
        m_reset();
        #1;
        check_state();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0;
        idle_inputs();
        m_reset();
        #12;
        check_state();
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        check_state();

        // Alloc three entries.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        chk_eq("d1_count", int'(bus.count), 3);
        chk_eq("d1_alloc_idx", int'(bus.alloc_idx), 3);
        chk_eq("d1_issue_valid", int'(bus.issue_valid), 0);

        // Mark 2 then 1; issue oldest first.
        cyc(0, 1, 2, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk_eq("d2_issue_idx_a", int'(bus.issue_idx), 1);
        cyc(0, 0, 0, 1, 0);
        chk_eq("d2_issue_idx_b", int'(bus.issue_idx), 2);
        cyc(0, 0, 0, 1, 0);
        chk_eq("d2_issue_valid", int'(bus.issue_valid), 0);

        // Wrapped occupancy: head=6, tail=4.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        chk_eq("d3_count", int'(bus.count), 6);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 7, 0, 0);
        chk_eq("d3_issue_idx", int'(bus.issue_idx), 7);

        // Full, then alloc+retire together: alloc refused, head advances.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_eq("d4_alloc_ready", int'(bus.alloc_ready), 0);
        cyc(1, 0, 0, 0, 1);
        chk_eq("d4_count", int'(bus.count), 7);
        chk_eq("d4_head", int'(bus.head_idx), 7);
        chk_eq("d4_alloc_idx", int'(bus.alloc_idx), 6);

        // Mark beats a same-cycle issue clear.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 3, 1, 0);
        chk_eq("d5_issue_valid", int'(bus.issue_valid), 1);
        chk_eq("d5_issue_idx", int'(bus.issue_idx), 3);

        // Illegal retire and mark are ignored.
        do_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 5, 0, 0);
        chk_eq("d6_count", int'(bus.count), 0);
        chk_eq("d6_issue_valid", int'(bus.issue_valid), 0);
`ifdef CYCLIC_PICKER_ERR_CHECK_EN
        chk_eq("d6_err", int'(err_sticky), 1);
        cyc(0, 0, 0, 0, 0);
        chk_eq("d6_err_hold", int'(err_sticky), 1);
`endif

        // Asynchronous reset between clock edges.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        #2;
        resetN = 1'b0;
        idle_inputs();
        m_reset();
        #1;
        chk_eq("d7_count", int'(bus.count), 0);
        chk_eq("d7_alloc_idx", int'(bus.alloc_idx), 0);
        check_state();
        @(negedge clk);
        resetN = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                int'($urandom_range(0, W - 1)), ($urandom_range(0, 99) < 45),
                ($urandom_range(0, 99) < 40));
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
